// File: rtl/ro_sweep_pkg.sv
// Shared state encoding, sizes and the mask-scan helper for the RO sweep controller.
package ro_sweep_pkg;
  localparam int N_RO   = 16;
  localparam int SEL_W  = $clog2(N_RO);
  localparam int SELP_W = SEL_W + 1;

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, DONE} state_e;

  // Lowest set mask bit at or above 'from'; the MSB of the result flags a hit.
  function automatic logic [SELP_W-1:0] next_set_bit(input logic [N_RO-1:0]   mask,
                                                     input logic [SELP_W-1:0] from);
    logic [SELP_W-1:0] res;
    res = '0;
    for (int i = N_RO - 1; i >= 0; i--) begin
      if (mask[i] && (SELP_W'(i) >= from)) res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction
endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes the muxed RO output, detects rising edges and counts them with saturation.
// Count lags the RO edge by three cycles; no backpressure, clr_i flushes chain and count.
module ro_edge_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ro_clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rise;

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous synced value.
  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d = clr_i ? 3'b000 : {sync_q[1:0], ro_clk_i};
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i && rise) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/ro_sweep_ctrl.sv
// Steps the RO mux through every enabled oscillator, settles, gates an edge count and stores it.
// Per entry SETTLE_CYC + gate + 1 cycles; start_i ignored while busy, abort_i wins over everything.
module ro_sweep_ctrl
  import ro_sweep_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cont_i,
  input  logic [N_RO-1:0]   ro_mask_i,
  input  logic [4:0]        stage_cfg_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic              ro_clk_i,
  output logic [SEL_W-1:0]  ro_sel_o,
  output logic [4:0]        stage_sel_o,
  output logic              busy_o,
  output logic              done_o,
  input  logic [SEL_W-1:0]  rd_addr_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_ovf_o
);
  localparam logic [GATE_W-1:0] SETTLE_LD = GATE_W'(SETTLE_CYC - 1);
  localparam logic [GATE_W-1:0] ONE       = GATE_W'(1);

  state_e            state_q, state_d;
  logic [N_RO-1:0]   mask_q, mask_d;
  logic [4:0]        stage_q, stage_d;
  logic [GATE_W-1:0] gate_q, gate_d, tmr_q, tmr_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SELP_W-1:0] first_hit, next_hit;
  logic              relatch, cnt_clr, cnt_en, do_store, cnt_ovf;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  res_cnt_q [N_RO];
  logic [N_RO-1:0]   res_ovf_q;
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_ovf_q;

  assign first_hit = next_set_bit(ro_mask_i, '0);
  assign next_hit  = next_set_bit(mask_q, {1'b0, idx_q} + SELP_W'(1));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    stage_d = stage_q;
    gate_d  = gate_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    relatch = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   relatch = start_i;
        SETTLE: begin
          if (tmr_q == '0) begin
            state_d = GATE;
            tmr_d   = gate_q - ONE;
          end else begin
            tmr_d = tmr_q - ONE;
          end
        end
        GATE: begin
          if (tmr_q == '0) state_d = STORE;
          else             tmr_d   = tmr_q - ONE;
        end
        STORE: begin
          if (next_hit[SEL_W]) begin
            idx_d   = next_hit[SEL_W-1:0];
            tmr_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          // busy_o is already low here, so a start in this cycle is honoured too.
          relatch = cont_i | start_i;
          if (!relatch) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (relatch) begin
      mask_d  = ro_mask_i;
      stage_d = stage_cfg_i;
      gate_d  = (gate_len_i == '0) ? ONE : gate_len_i;
      tmr_d   = SETTLE_LD;
      if (first_hit[SEL_W]) begin
        idx_d   = first_hit[SEL_W-1:0];
        state_d = SETTLE;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      stage_q <= '0;
      gate_q  <= '0;
      tmr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      stage_q <= stage_d;
      gate_q  <= gate_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
    end
  end

  // Flush on the first settle cycle so the chain refills from the newly selected oscillator.
  assign cnt_clr  = (state_q == SETTLE) && (tmr_q == SETTLE_LD);
  assign cnt_en   = (state_q == GATE);
  assign do_store = (state_q == STORE) && !abort_i;

  ro_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .ro_clk_i (ro_clk_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .cnt_o    (cnt),
    .ovf_o    (cnt_ovf)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < N_RO; i++) res_cnt_q[i] <= '0;
      res_ovf_q <= '0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      if (do_store) begin
        res_cnt_q[idx_q] <= cnt;
        res_ovf_q[idx_q] <= cnt_ovf;
      end
      rd_data_q <= res_cnt_q[rd_addr_i];
      rd_ovf_q  <= res_ovf_q[rd_addr_i];
    end
  end

  assign ro_sel_o    = idx_q;
  assign stage_sel_o = stage_q;
  assign busy_o      = (state_q == SETTLE) || (state_q == GATE) || (state_q == STORE);
  assign done_o      = (state_q == DONE);
  assign rd_data_o   = rd_data_q;
  assign rd_ovf_o    = rd_ovf_q;
endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Directed-plus-random bench: expected counts come from gate/period arithmetic, timing from cycle formulas.
module tb_ro_sweep_ctrl;
  localparam int SETTLE = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        start_i, abort_i, cont_i;
  logic [15:0] ro_mask_i, gate_len_i;
  logic [4:0]  stage_cfg_i;
  logic        ro_clk_i = 1'b0;
  logic [3:0]  ro_sel_o, rd_addr_i;
  logic [4:0]  stage_sel_o;
  logic        busy_o, done_o;
  logic [19:0] rd_data_o;
  logic        rd_ovf_o;

  logic        start4;
  logic [15:0] mask4, gate4;
  logic        ro_clk4 = 1'b0;
  logic [3:0]  ro_sel4, rd_addr4;
  logic [4:0]  stage_sel4;
  logic        busy4, done4;
  logic [3:0]  rd_data4;
  logic        rd_ovf4;

  int n_vec = 0;
  int n_err = 0;
  int ro_half [16];
  int exp_lo [16];
  int exp_hi [16];

  always #5 wb_clk_i = ~wb_clk_i;

  ro_sweep_ctrl u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start_i(start_i), .abort_i(abort_i),
    .cont_i(cont_i), .ro_mask_i(ro_mask_i), .stage_cfg_i(stage_cfg_i), .gate_len_i(gate_len_i),
    .ro_clk_i(ro_clk_i), .ro_sel_o(ro_sel_o), .stage_sel_o(stage_sel_o), .busy_o(busy_o),
    .done_o(done_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_ovf_o(rd_ovf_o)
  );

  ro_sweep_ctrl #(.CNT_W(4)) u_dut4 (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start_i(start4), .abort_i(1'b0),
    .cont_i(1'b0), .ro_mask_i(mask4), .stage_cfg_i(5'h00), .gate_len_i(gate4),
    .ro_clk_i(ro_clk4), .ro_sel_o(ro_sel4), .stage_sel_o(stage_sel4), .busy_o(busy4),
    .done_o(done4), .rd_addr_i(rd_addr4), .rd_data_o(rd_data4), .rd_ovf_o(rd_ovf4)
  );

  // Bank model: the selected oscillator toggles every ro_half[sel] clock cycles.
  int ro_div = 0;
  always @(posedge wb_clk_i) begin
    #2;
    ro_div++;
    if (ro_div >= ro_half[ro_sel_o]) begin
      ro_div   = 0;
      ro_clk_i = ~ro_clk_i;
    end
  end

  int ro_div4 = 0;
  always @(posedge wb_clk_i) begin
    #2;
    ro_div4++;
    if (ro_div4 >= 2) begin
      ro_div4 = 0;
      ro_clk4 = ~ro_clk4;
    end
  end

  int         done_cnt = 0;
  bit         busy_seen = 0;
  bit         busy_prev = 0;
  logic [3:0] sel_prev = '0;
  logic [3:0] visited [$];
  always @(negedge wb_clk_i) begin
    if (done_o) done_cnt++;
    if (busy_o) busy_seen = 1;
    if (busy_o && (!busy_prev || ro_sel_o != sel_prev)) visited.push_back(ro_sel_o);
    busy_prev = busy_o;
    sel_prev  = ro_sel_o;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  // A G-cycle window over a period-P square wave holds floor or ceil of G/P rising edges; allow +/-1.
  task automatic model_store(input logic [15:0] m, input int g);
    int p, ge;
    ge = (g == 0) ? 1 : g;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        p = 2 * ro_half[i];
        exp_lo[i] = (ge + p - 1) / p - 1;
        if (exp_lo[i] < 0) exp_lo[i] = 0;
        exp_hi[i] = ge / p + 1;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      exp_lo[i] = 0;
      exp_hi[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      @(negedge wb_clk_i);
      chk_rng($sformatf("%s_cnt%0d", tag, i), int'(rd_data_o), exp_lo[i], exp_hi[i]);
      chk($sformatf("%s_ovf%0d", tag, i), int'(rd_ovf_o), 0);
    end
  endtask

  // Start a sweep, scramble the live inputs to prove they were latched, optionally poke start mid-run.
  task automatic run_sweep(input logic [15:0] m, input int g, input bit poke, output int cyc);
    logic [4:0] st;
    st = 5'($urandom) | 5'h01;
    @(negedge wb_clk_i);
    ro_mask_i = m; gate_len_i = 16'(g); stage_cfg_i = st; start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    cyc = 1;
    if (m != 16'h0000) begin
      chk("busy_after_start", int'(busy_o), 1);
      chk("stage_latched", int'(stage_sel_o), int'(st));
    end
    ro_mask_i = 16'($urandom); gate_len_i = 16'($urandom_range(1, 300)); stage_cfg_i = ~st;
    while (!done_o && cyc < 6000) begin
      start_i = (poke && cyc == 30);
      @(negedge wb_clk_i);
      cyc++;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int cyc, g, nset;
    logic [15:0] m;

    wb_rst_ni = 1'b0; start_i = 0; abort_i = 0; cont_i = 0;
    ro_mask_i = '0; gate_len_i = '0; stage_cfg_i = '0; rd_addr_i = '0;
    start4 = 0; mask4 = '0; gate4 = '0; rd_addr4 = '0;
    for (int i = 0; i < 16; i++) ro_half[i] = 2;
    model_clear();
    tick(3);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_sel", int'(ro_sel_o), 0);
    chk("rst_stage", int'(stage_sel_o), 0);
    chk("rst_rd", int'(rd_data_o), 0);
    wb_rst_ni = 1'b1;
    tick(2);
    check_all("init");

    // Full sweep, clk/4 on every oscillator, with an ignored start mid-sweep.
    visited.delete();
    run_sweep(16'hFFFF, 100, 1, cyc);
    chk("full_done_cyc", cyc, 1 + 16 * (SETTLE + 100 + 1));
    chk("full_visit_n", visited.size(), 16);
    for (int i = 0; i < 16 && i < visited.size(); i++) chk($sformatf("full_visit%0d", i), int'(visited[i]), i);
    model_store(16'hFFFF, 100);
    check_all("full");

    // Empty mask: immediate done, never busy, results untouched.
    busy_seen = 0;
    run_sweep(16'h0000, 50, 0, cyc);
    chk("zero_done_cyc", cyc, 1);
    tick(2);
    chk("zero_busy_seen", int'(busy_seen), 0);
    check_all("zero");

    // Endpoints only, distinct per-oscillator rates.
    for (int i = 0; i < 16; i++) ro_half[i] = int'($urandom_range(2, 5));
    g = int'($urandom_range(40, 120));
    visited.delete();
    run_sweep(16'h8001, g, 1, cyc);
    chk("ends_done_cyc", cyc, 1 + 2 * (SETTLE + g + 1));
    chk("ends_visit_n", visited.size(), 2);
    if (visited.size() == 2) begin
      chk("ends_visit0", int'(visited[0]), 0);
      chk("ends_visit1", int'(visited[1]), 15);
    end
    model_store(16'h8001, g);
    check_all("ends");

    // Random masks and gates.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) ro_half[i] = int'($urandom_range(2, 5));
      m = 16'($urandom);
      if (m == 16'h0000) m = 16'h0100;
      g = int'($urandom_range(20, 100));
      nset = $countones(m);
      run_sweep(m, g, 0, cyc);
      chk($sformatf("rand%0d_done_cyc", r), cyc, 1 + nset * (SETTLE + g + 1));
      model_store(m, g);
      check_all($sformatf("rand%0d", r));
    end

    // Gate length 0 behaves as 1.
    run_sweep(16'h0010, 0, 0, cyc);
    chk("gate0_done_cyc", cyc, 1 + SETTLE + 1 + 1);
    model_store(16'h0010, 0);
    check_all("gate0");

    // Abort mid-GATE on entry 3 together with a start.
    @(negedge wb_clk_i);
    ro_mask_i = 16'h0009; gate_len_i = 16'd100; start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (ro_sel_o != 4'd3 && cyc < 1000) begin
      @(negedge wb_clk_i);
      cyc++;
    end
    chk("abort_reach_idx3", int'(ro_sel_o), 3);
    tick(20);
    done_cnt = 0;
    abort_i = 1'b1; start_i = 1'b1;
    @(negedge wb_clk_i);
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort_idle_next", int'(busy_o), 0);
    tick(150);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_start_ignored", int'(busy_o), 0);
    model_store(16'h0001, 100);
    check_all("abort");

    // Saturation on the 4-bit instance, then a short gate clears the flag.
    @(negedge wb_clk_i);
    mask4 = 16'h0001; gate4 = 16'd100; start4 = 1'b1;
    @(negedge wb_clk_i);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 2000) begin @(negedge wb_clk_i); cyc++; end
    chk("sat_done_cyc", cyc, SETTLE + 100 + 1);
    rd_addr4 = 4'd0;
    @(negedge wb_clk_i);
    chk("sat_cnt", int'(rd_data4), 15);
    chk("sat_ovf", int'(rd_ovf4), 1);
    gate4 = 16'd20; start4 = 1'b1;
    @(negedge wb_clk_i);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 2000) begin @(negedge wb_clk_i); cyc++; end
    @(negedge wb_clk_i);
    chk_rng("unsat_cnt", int'(rd_data4), 4, 6);
    chk("unsat_ovf", int'(rd_ovf4), 0);

    // Continuous mode period, then reset mid-sweep.
    for (int i = 0; i < 16; i++) ro_half[i] = int'($urandom_range(2, 5));
    @(negedge wb_clk_i);
    ro_mask_i = 16'h0003; gate_len_i = 16'd30; stage_cfg_i = 5'h15; cont_i = 1'b1; start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 2000) begin @(negedge wb_clk_i); cyc++; end
    chk("cont_first_cyc", cyc, 1 + 2 * (SETTLE + 30 + 1));
    @(negedge wb_clk_i);
    cyc = 1;
    while (!done_o && cyc < 2000) begin @(negedge wb_clk_i); cyc++; end
    chk("cont_period_cyc", cyc, 2 * (SETTLE + 30 + 1) + 1);
    model_store(16'h0003, 30);
    rd_addr_i = 4'd0;
    tick(20);
    chk_rng("cont_pre_rst_rd", int'(rd_data_o), exp_lo[0], exp_hi[0]);
    chk("cont_busy_mid", int'(busy_o), 1);
    wb_rst_ni = 1'b0; cont_i = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    chk("mid_rst_sel", int'(ro_sel_o), 0);
    chk("mid_rst_stage", int'(stage_sel_o), 0);
    chk("mid_rst_rd", int'(rd_data_o), 0);
    chk("mid_rst_ovf", int'(rd_ovf_o), 0);
    tick(2);
    wb_rst_ni = 1'b1;
    model_clear();
    tick(1);
    check_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
